// File: rtl/fb_pkg.sv
// Shared constants, pixel type and controller states for the framebuffer write arbiter.
// Geometry defaults describe a 640x480 active frame.
package fb_pkg;

    localparam int FB_WIDTH   = 640;
    localparam int FB_HEIGHT  = 480;
    localparam int FB_TOT_PIX = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W  = $clog2(FB_TOT_PIX);

    typedef logic [23:0] pixel_t;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after i_ptr+1 (mod NREQ) wins.
// Purely combinational; one-hot grant plus binary index.
module rr_arbiter
    import fb_pkg::*;
#(
    parameter  int NREQ  = 2,
    localparam int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = IDX_W'((int'(i_ptr) + i) % NREQ);
            if (!o_any && i_req[w_cand]) begin
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
                o_any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer write port between NREQ pixel requesters and a full-screen clear.
// Define FB_BLANK_WRITE_EN to restrict all writes to blanking time (de=0).
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter  int WIDTH   = FB_WIDTH,
    parameter  int HEIGHT  = FB_HEIGHT,
    parameter  int NREQ    = 2,
    localparam int TOT_PIX = WIDTH * HEIGHT,
    localparam int ADDR_W  = $clog2(TOT_PIX),
    localparam int IDX_W   = idx_w(NREQ)
) (
    input  logic                clk_pix,
    input  logic                rst,
    input  logic                de,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*10-1:0]  req_x,
    input  logic [NREQ*10-1:0]  req_y,
    input  logic [NREQ*24-1:0]  req_data,
    input  logic                clear_start,
    input  logic [23:0]         clear_color,
    output logic                clear_busy,
    output logic                err_oob,
    output logic                fb_we,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [23:0]         fb_data
);

    localparam logic [10:0] X_LIM = 11'(WIDTH);
    localparam logic [10:0] Y_LIM = 11'(HEIGHT);

    logic [9:0] w_x [NREQ];
    logic [9:0] w_y [NREQ];
    pixel_t     w_d [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_x[gi] = req_x[gi*10 +: 10];
        assign w_y[gi] = req_y[gi*10 +: 10];
        assign w_d[gi] = req_data[gi*24 +: 24];
    end

    state_t             r_state, w_next;
    logic [IDX_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]  r_cnt, w_cnt_next;
    pixel_t             r_color;
    logic               w_gate;

`ifdef FB_BLANK_WRITE_EN
    assign w_gate = ~de;
`else
    // de has no effect on the ungated build.
    assign w_gate = de | 1'b1;
`endif

    logic [NREQ-1:0]  w_arb_req, w_gnt;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;

    assign w_arb_req = (r_state == ARB && w_gate && !clear_start) ? req_valid : '0;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .i_req (w_arb_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign req_ready = w_gnt;

    logic [9:0]        w_sel_x, w_sel_y;
    pixel_t            w_sel_d;
    logic              w_oob, w_req_wr;
    logic [ADDR_W-1:0] w_lin;

    assign w_sel_x  = w_x[w_idx];
    assign w_sel_y  = w_y[w_idx];
    assign w_sel_d  = w_d[w_idx];
    assign w_oob    = ({1'b0, w_sel_x} >= X_LIM) || ({1'b0, w_sel_y} >= Y_LIM);
    assign w_req_wr = w_any && !w_oob;
    assign w_lin    = ADDR_W'(32'(w_sel_y) * WIDTH + 32'(w_sel_x));

    // A clear's first pixel goes out on the same edge that accepts clear_start.
    logic              w_start, w_clr_wr, w_clr_last;
    logic [ADDR_W-1:0] w_clr_addr;
    pixel_t            w_clr_data;

    assign w_start    = (r_state == ARB) && clear_start;
    assign w_clr_wr   = w_gate && (w_start || r_state == CLEAR);
    assign w_clr_addr = (r_state == ARB) ? '0 : r_cnt;
    assign w_clr_data = (r_state == ARB) ? clear_color : r_color;
    assign w_clr_last = (w_clr_addr == ADDR_W'(TOT_PIX - 1));

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ARB: begin
                if (clear_start) begin
                    w_next     = CLEAR;
                    w_cnt_next = w_gate ? ADDR_W'(1) : '0;
                end
            end
            CLEAR: begin
                if (w_gate) begin
                    if (w_clr_last) begin
                        w_next     = ARB;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + ADDR_W'(1);
                    end
                end
            end
            default: w_next = ARB;
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst) begin
        if (!rst) begin
            r_state <= ARB;
            r_cnt   <= '0;
            r_ptr   <= IDX_W'(NREQ - 1);
            r_color <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_any)   r_ptr   <= w_idx;
            if (w_start) r_color <= clear_color;
        end
    end

    always_ff @(posedge clk_pix or negedge rst) begin
        if (!rst) begin
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            err_oob    <= 1'b0;
            clear_busy <= 1'b0;
        end else begin
            fb_we      <= w_clr_wr | w_req_wr;
            err_oob    <= w_any & w_oob;
            clear_busy <= w_clr_wr | (w_next == CLEAR);
            if (w_clr_wr) begin
                fb_addr <= w_clr_addr;
                fb_data <= w_clr_data;
            end else if (w_req_wr) begin
                fb_addr <= w_lin;
                fb_data <= w_sel_d;
            end
        end
    end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Shares the single framebuffer write port (videoRam port A) between NREQ pixel-writing requesters and an internal full-screen clear sequencer. Each requester presents (x, y, pixel) over a valid/ready handshake; the block grants round-robin, converts coordinates to a linear address (y*WIDTH + x), and drives registered write-enable, address and data toward the framebuffer in the clk_pix domain, upstream of the DVI path.

## Interface
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines
- NREQ, 2, number of requesters (1..4)
- Derived: TOT_PIX = WIDTH*HEIGHT; ADDR_W = $clog2(TOT_PIX) (19 at defaults)

- clk_pix  input  1  pixel clock; only clock
- rst  input  1  asynchronous, active-low reset
- de  input  1  display-active flag from scrn_pos
- req_valid  input  NREQ  per-requester write request
- req_ready  output  NREQ  per-requester accept (combinational)
- req_x  input  NREQ*10  x coordinate, requester i at [10i+9:10i]
- req_y  input  NREQ*10  y coordinate, same packing
- req_data  input  NREQ*24  pixel {R,G,B}, requester i at [24i+23:24i]
- clear_start  input  1  one-cycle pulse: fill screen with clear_color
- clear_color  input  24  fill pixel, sampled with clear_start
- clear_busy  output  1  clear in progress
- err_oob  output  1  one-cycle pulse: accepted request had x>=WIDTH or y>=HEIGHT
- fb_we  output  1  framebuffer write enable
- fb_addr  output  ADDR_W  framebuffer write address
- fb_data  output  24  framebuffer write data

## Operation
- States: ARB (reset state), CLEAR.
- ARB: the round-robin arbiter picks the first valid requester at or after index rr_ptr+1 (mod NREQ). Only that requester sees req_ready=1, and only when the write gate is open (see Configuration) and clear_start=0.
- Transfer occurs on valid&ready. rr_ptr becomes the granted index on a transfer only.
- Requesters hold valid, x, y and data stable until accepted. Valid may not be withdrawn.
- In-range transfer: the next cycle has fb_we=1, fb_addr=y*WIDTH+x, fb_data=data.
- Out-of-range transfer: accepted and dropped. The next cycle has fb_we=0 and err_oob=1.
- clear_start in ARB: latch clear_color, go to CLEAR, reset the clear counter to 0. clear_start wins over any same-cycle request; all req_ready are 0 that cycle.
- CLEAR: each gated-open cycle writes clear_color to counter address, then increments the counter. After address TOT_PIX-1 is written, return to ARB. All req_ready are held 0. clear_start is ignored while in CLEAR.
- Outputs are all registered. fb_we is 0 on any cycle with no write.

## Timing
- Reset values: fb_we=0, fb_addr=0, fb_data=0, clear_busy=0, err_oob=0, state=ARB, rr_ptr=NREQ-1 (requester 0 has first priority), clear counter=0.
- Request latency: acceptance at edge k gives fb_we at cycle k+1. Throughput is one write per cycle. Back-to-back grants are allowed.
- Clear, ungated: clear_start at edge k.
  - clear_busy=1 and the first write (addr 0) at cycle k+1.
  - Last write (addr TOT_PIX-1) at cycle k+TOT_PIX.
  - clear_busy=0 at k+TOT_PIX+1.
  - Requests may be accepted from edge k+TOT_PIX onward, with the write at cycle k+TOT_PIX+1.
- Counter wraps only by returning to ARB. It never exceeds TOT_PIX-1.
- Assertion of rst mid-clear aborts immediately to the reset values. A partially cleared frame is acceptable.

## Configuration
- FB_BLANK_WRITE_EN defined: the write gate is open only when de=0. In ARB, all req_ready=0 while de=1. In CLEAR, the counter stalls and fb_we=0 while de=1. This avoids read/write contention on displayed pixels.
- Undefined: the gate is always open, and de is unused.

## Structure
- Package fb_pkg holds WIDTH/HEIGHT defaults, TOT_PIX, ADDR_W, typedef pixel_t (logic [23:0]), and the state enum {ARB, CLEAR}.
- One sub-module, rr_arbiter: NREQ-wide round-robin grant from a request vector and rr_ptr, producing a one-hot grant and an index.
- Coordinate multiply: y*WIDTH as a registered constant multiply in the output stage.

## Test plan
- Single request: requester 0 with x=5, y=2, data=0xFF0000 → req_ready[0]=1 the same cycle; next cycle fb_we=1, fb_addr=1285, fb_data=0xFF0000.
- Contention: both requesters valid continuously with 3 requests each → grants alternate 0,1,0,1,0,1, one fb_we per cycle, 6 writes total.
- Out of range: x=640, y=0 → accepted, err_oob=1 next cycle, fb_we=0.
- Clear: clear_start with color 0x0000FF, macro undefined → 307200 consecutive writes, addr 0..307199, then clear_busy falls. A request held valid throughout is accepted only after the clear ends.
- Gating with FB_BLANK_WRITE_EN: request while de=1 → req_ready=0 until de=0; clear stalls while de=1.
- Reset mid-clear at counter 1000 → all outputs return to reset values, then a fresh clear_start restarts from addr 0.
